unidade_busca: RTL and testbench
================================

# unidade_busca

Instruction-fetch stage of the single-cycle/pipelined MIPS-like core. Holds the program counter, drives the address of the instruction memory, and latches the returned word into the fetch/decode register. Handles stall, redirect from execute, early redirect on an immediate jump (JI), and a halt instruction. Sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
- TAM_MEM, 32: instruction memory depth in words, power of two; PC wraps modulo TAM_MEM
- OPCODE_JI, 5'b10100: opcode (bits [31:27]) of immediate jump; target in bits [25:0]
- OPCODE_HALT, 5'b11111: opcode of halt
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instrucao_mem  in  32  word read combinationally from instruction memory at endereco
- parar  in  1  stall from downstream; hold PC and fetch register
- desvio  in  1  redirect request from execute
- alvo_desvio  in  32  redirect target word address
- endereco  out  32  PC, word address into instruction memory
- instrucao  out  32  fetched instruction (fetch/decode register)
- pc_instrucao  out  32  address instrucao was fetched from
- valida  out  1  instrucao is a real fetched instruction
- parado  out  1  core halted

## Operation
- States: INICIO, BUSCA, PARADO.
- INICIO: one cycle after reset; no capture (memory performs its first-edge initialization). Next: BUSCA, or BUSCA at alvo_desvio if desvio.
- BUSCA, per cycle, priority order:
  - desvio=1 (wins over parar): endereco<=alvo_desvio&(TAM_MEM-1); instrucao<=0 (NOP); valida<=0.
  - parar=1: all registers hold.
  - otherwise capture: instrucao<=instrucao_mem; pc_instrucao<=endereco; valida<=1; then next PC:
    - opcode==OPCODE_JI (macro enabled): endereco<=instrucao_mem[25:0]&(TAM_MEM-1).
    - opcode==OPCODE_HALT: endereco holds; go PARADO; parado<=1.
    - else endereco<=(endereco+1)&(TAM_MEM-1); TAM_MEM-1 wraps to 0.
- PARADO: instrucao<=0, valida<=0, endereco holds, parar ignored. Leave only by reset or desvio (to BUSCA at alvo_desvio, parado<=0).
- endereco bits above log2(TAM_MEM) always 0.

## Timing
- Reset values: endereco=0, instrucao=0, pc_instrucao=0, valida=0, parado=0, state INICIO.
- Reset wins over every input, in any state, mid-stall or mid-halt.
- Fetch latency: word at address A appears on instrucao one edge after endereco=A with parar=0.
- Throughput: one instruction per cycle when not stalled.
- JI (macro on): zero bubbles; target fetched the cycle after JI is captured.
- desvio: one bubble (valida=0 for one cycle), target captured next cycle.
- Stall and desvio same cycle: desvio taken, stall ignored.

## Configuration
- BUSCA_SALTO_ANTECIPADO_EN defined: JI decoded in fetch, PC redirected as above.
- Undefined: no opcode inspection for JI; JI is captured and PC increments; the jump resolves only via desvio from execute. HALT detection present in both builds.

## Test plan
- Memory 0..5 = NOP, LOAD, LOAD, ADD, ADDI, JI 10; reset 2 cycles, run -> endereco 0,0(INICIO),1,2,3,4,5,10,11; pc_instrucao follows one cycle later; valida=1 from first capture.
- Same program, macro undefined -> endereco 5,6,7; drive desvio=1, alvo_desvio=10 when JI in execute -> one valida=0 bubble, then pc_instrucao=10.
- parar=1 for 3 cycles at endereco=3 -> endereco, instrucao, pc_instrucao frozen 3 cycles; desvio=1 during stall -> redirect taken, instrucao=0, valida=0.
- HALT at word 7 -> parado=1 next edge, endereco stays 7, valida=0 afterwards; desvio to 0 -> parado=0, fetch resumes at 0.
- PC at 31 (TAM_MEM=32), plain instruction -> endereco wraps to 0; alvo_desvio=40 -> endereco=8.
- reset=1 asserted mid-stream and while PARADO -> all outputs return to reset values next edge, INICIO cycle repeats.

Source files
------------

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage (PC, instruction memory address, fetch/decode register)
// Optional feature macro: BUSCA_SALTO_ANTECIPADO_EN (decode immediate jump JI in fetch)
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   instrucao_mem      word read combinationally from memory at endereco
//   parar              stall from downstream, holds PC and fetch register
//   desvio/alvo_desvio redirect request and target word address from execute
//   endereco           PC, word address into instruction memory
//   instrucao          fetched instruction
//   pc_instrucao       address instrucao was fetched from
//   valida             instrucao is a real fetched instruction
//   parado             core halted
module unidade_busca #(
    parameter int         TAM_MEM     = 32,
    parameter logic [4:0] OPCODE_JI   = 5'b10100,
    parameter logic [4:0] OPCODE_HALT = 5'b11111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao_mem,
    input  logic        parar,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    output logic [31:0] endereco,
    output logic [31:0] instrucao,
    output logic [31:0] pc_instrucao,
    output logic        valida,
    output logic        parado
);
`ifdef BUSCA_SALTO_ANTECIPADO_EN
    localparam bit SALTO_ANTECIPADO = 1'b1;
`else
    localparam bit SALTO_ANTECIPADO = 1'b0;
`endif
    localparam logic [31:0] MASCARA = 32'(TAM_MEM - 1);
    typedef enum logic [1:0] {INICIO, BUSCA, PARADO} estado_t;
    estado_t     estado;
    logic [4:0]  opcode;
    logic [31:0] proximo;
    logic [31:0] alvo;
    assign opcode = instrucao_mem[31:27];
    assign alvo   = alvo_desvio & MASCARA;
    always_comb begin
        proximo = (SALTO_ANTECIPADO && opcode == OPCODE_JI) ? ({6'd0, instrucao_mem[25:0]} & MASCARA)
                                                            : ((endereco + 32'd1) & MASCARA);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= INICIO;
            endereco     <= '0;
            instrucao    <= '0;
            pc_instrucao <= '0;
            valida       <= 1'b0;
            parado       <= 1'b0;
        end else begin
            case (estado)
                // memory does its first-edge initialization here, nothing is captured
                INICIO: begin
                    estado <= BUSCA;
                    if (desvio) endereco <= alvo;
                end
                BUSCA: begin
                    if (desvio) begin
                        endereco  <= alvo;
                        instrucao <= '0;
                        valida    <= 1'b0;
                    end else if (!parar) begin
                        instrucao    <= instrucao_mem;
                        pc_instrucao <= endereco;
                        valida       <= 1'b1;
                        if (opcode == OPCODE_HALT) begin
                            estado <= PARADO;
                            parado <= 1'b1;
                        end else begin
                            endereco <= proximo;
                        end
                    end
                end
                PARADO: begin
                    instrucao <= '0;
                    valida    <= 1'b0;
                    if (desvio) begin
                        endereco <= alvo;
                        estado   <= BUSCA;
                        parado   <= 1'b0;
                    end
                end
                default: estado <= INICIO;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: randomized bench for unidade_busca against a cycle-level behavioural model
module tb_unidade_busca;
    localparam int TAM = 32;
`ifdef BUSCA_SALTO_ANTECIPADO_EN
    localparam bit JI_EN = 1'b1;
`else
    localparam bit JI_EN = 1'b0;
`endif
    logic        clock = 1'b0;
    logic        reset, parar, desvio;
    logic [31:0] instrucao_mem, alvo_desvio, endereco, instrucao, pc_instrucao;
    logic        valida, parado;
    logic [31:0] mem [TAM];
    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc, m_ins, m_pci;
    logic        m_val, m_halt, m_fresh;

    always #5 clock = ~clock;
    assign instrucao_mem = mem[endereco[4:0]];

    unidade_busca #(.TAM_MEM(TAM)) dut (
        .clock(clock), .reset(reset), .instrucao_mem(instrucao_mem), .parar(parar),
        .desvio(desvio), .alvo_desvio(alvo_desvio), .endereco(endereco), .instrucao(instrucao),
        .pc_instrucao(pc_instrucao), .valida(valida), .parado(parado)
    );

    task automatic comparar(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nome, $time, atual, esperado);
        end
    endtask

    // one clock: drive inputs, advance the model, then check all outputs away from the edge
    task automatic passo(input logic r, input logic p, input logic d, input logic [31:0] a);
        logic [31:0] w;
        reset = r; parar = p; desvio = d; alvo_desvio = a;
        w = mem[m_pc % TAM];
        if (r) begin
            m_pc = 0; m_ins = 0; m_pci = 0; m_val = 0; m_halt = 0; m_fresh = 1;
        end else if (m_fresh) begin
            m_fresh = 0;
            if (d) m_pc = a % TAM;
        end else if (m_halt) begin
            m_ins = 0; m_val = 0;
            if (d) begin m_pc = a % TAM; m_halt = 0; end
        end else if (d) begin
            m_pc = a % TAM; m_ins = 0; m_val = 0;
        end else if (!p) begin
            m_ins = w; m_pci = m_pc; m_val = 1;
            if (w[31:27] == 5'b11111) m_halt = 1;
            else if (JI_EN && w[31:27] == 5'b10100) m_pc = {6'd0, w[25:0]} % TAM;
            else m_pc = (m_pc + 1) % TAM;
        end
        @(negedge clock);
        comparar("endereco", endereco, m_pc);
        comparar("instrucao", instrucao, m_ins);
        comparar("pc_instrucao", pc_instrucao, m_pci);
        comparar("valida", {31'd0, valida}, {31'd0, m_val});
        comparar("parado", {31'd0, parado}, {31'd0, m_halt});
    endtask

    initial begin
        for (int i = 0; i < TAM; i++) mem[i] = {5'b00010, 27'(i)};
        mem[0] = 32'd0;
        mem[1] = {5'b00001, 27'd1};
        mem[2] = {5'b00001, 27'd2};
        mem[3] = {5'b00011, 27'd3};
        mem[4] = {5'b00100, 27'd4};
        mem[5] = {5'b10100, 1'b0, 26'd10};
        mem[7] = {5'b11111, 27'd0};

        // straight-line program with JI at word 5
        passo(1, 0, 0, 0);
        passo(1, 0, 0, 0);
        comparar("lit_reset_endereco", endereco, 0);
        comparar("lit_reset_valida", {31'd0, valida}, 0);
        for (int i = 0; i < 7; i++) begin
            passo(0, 0, 0, 0);
            comparar("lit_seq_endereco", endereco, (JI_EN && i == 6) ? 32'd10 : 32'(i));
        end
        comparar("lit_seq_pc_instrucao", pc_instrucao, 5);
        comparar("lit_seq_valida", {31'd0, valida}, 1);
        passo(0, 0, 1, 10);
        comparar("lit_desvio_bolha", {31'd0, valida}, 0);
        comparar("lit_desvio_endereco", endereco, 10);
        passo(0, 0, 0, 0);
        comparar("lit_desvio_pc_instrucao", pc_instrucao, 10);
        comparar("lit_desvio_valida", {31'd0, valida}, 1);

        // stall at endereco 3, then redirect during stall with wrapped target
        passo(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) passo(0, 0, 0, 0);
        comparar("lit_pre_stall_endereco", endereco, 3);
        for (int i = 0; i < 3; i++) begin
            passo(0, 1, 0, 0);
            comparar("lit_stall_endereco", endereco, 3);
            comparar("lit_stall_pc_instrucao", pc_instrucao, 2);
            comparar("lit_stall_instrucao", instrucao, mem[2]);
        end
        passo(0, 1, 1, 40);
        comparar("lit_stall_desvio_endereco", endereco, 8);
        comparar("lit_stall_desvio_instrucao", instrucao, 0);
        comparar("lit_stall_desvio_valida", {31'd0, valida}, 0);

        // halt at word 7, resume by redirect to 0
        passo(1, 0, 0, 0);
        passo(0, 0, 1, 7);
        comparar("lit_inicio_desvio", endereco, 7);
        passo(0, 0, 0, 0);
        comparar("lit_halt_parado", {31'd0, parado}, 1);
        comparar("lit_halt_endereco", endereco, 7);
        passo(0, 1, 0, 0);
        comparar("lit_halt_valida", {31'd0, valida}, 0);
        comparar("lit_halt_hold", endereco, 7);
        passo(0, 0, 1, 0);
        comparar("lit_resume_parado", {31'd0, parado}, 0);
        comparar("lit_resume_endereco", endereco, 0);
        passo(0, 0, 0, 0);
        comparar("lit_resume_pc_instrucao", pc_instrucao, 0);

        // wrap from 31 to 0
        passo(0, 0, 1, 31);
        passo(0, 0, 0, 0);
        comparar("lit_wrap_endereco", endereco, 0);
        comparar("lit_wrap_pc_instrucao", pc_instrucao, 31);

        // reset while halted
        passo(0, 0, 1, 7);
        passo(0, 0, 0, 0);
        passo(1, 0, 0, 0);
        comparar("lit_reset_halt_parado", {31'd0, parado}, 0);
        comparar("lit_reset_halt_endereco", endereco, 0);

        // randomized traffic with occasional program rewrites
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 5) begin
                logic [31:0] w;
                int k;
                w = $urandom;
                k = $urandom_range(0, 9);
                if (k < 2) w[31:27] = 5'b10100;
                else if (k == 2) w[31:27] = 5'b11111;
                mem[$urandom_range(0, TAM - 1)] = w;
            end
            passo($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 8, $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
